uart_tx_arbiter: RTL and testbench

Shares one serial TX pin between NUM_REQ byte-producing requesters, e.g. the LED status, seven-segment counter and bus-monitor sources of the IO fabric. It arbitrates round-robin and frames each granted byte as 8N1 UART at CLKS_PER_BIT clocks per bit. It sits between the fabric's byte sources and the TX0 output and replaces the plain RX0→TX0 loopback when debug streaming is enabled.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the round-robin UART TX arbiter.
// Frame-length constants cover both the plain and the UART_TX_ARBITER_PARITY_EN builds.
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned FRAME_BITS = UART_DATA_BITS + 2;
  localparam int unsigned FRAME_BITS_PARITY = UART_DATA_BITS + 3;

  // The PARITY code is always reserved so both builds share one encoding.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin arbiter: combinational search from a registered pointer.
// The pointer moves to the slot after the winner on every accepted grant.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 accept,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdxW'((32'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART TX line between NUM_REQ byte sources, round-robin.
// Define UART_TX_ARBITER_PARITY_EN to append an even-parity bit (11-bit frame).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(UART_DATA_BITS);

  uart_state_e               state_q, state_d;
  logic [BaudW-1:0]          baud_q, baud_d;
  logic [BitW-1:0]           bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d, sel_data;
  logic                      tx_q, tx_d;
  logic [IdxW-1:0]           grant_id_q, grant_id_d, win_idx;
  logic [NUM_REQ-1:0]        grant;
  logic                      accept, baud_wrap;
`ifdef UART_TX_ARBITER_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (win_idx)
  );

  assign accept    = (state_q == StIdle) && (|req_valid);
  assign req_ready = (state_q == StIdle) ? grant : '0;
  assign baud_wrap = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) sel_data = req_data[8*i +: 8];
    end
  end

  // tx_d is computed from the state being entered so tx is a clean register output.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_wrap ? '0 : baud_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    grant_id_d = grant_id_q;
`ifdef UART_TX_ARBITER_PARITY_EN
    parity_d   = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (accept) begin
          state_d    = StStart;
          shift_d    = sel_data;
          tx_d       = 1'b0;
          grant_id_d = win_idx;
`ifdef UART_TX_ARBITER_PARITY_EN
          parity_d   = ^sel_data;
`endif
        end
      end
      StStart: begin
        if (baud_wrap) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (baud_wrap) begin
          if (bit_q == BitW'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_ARBITER_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_ARBITER_PARITY_EN
      StParity: begin
        if (baud_wrap) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_wrap) begin
          state_d = StIdle;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      grant_id_q <= '0;
`ifdef UART_TX_ARBITER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      grant_id_q <= grant_id_d;
`ifdef UART_TX_ARBITER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with NUM_REQ=4, CLKS_PER_BIT=4.
// Honours UART_TX_ARBITER_PARITY_EN for the 11-bit frame variant.
module tb_uart_tx_arbiter;

  localparam int NumReq = 4;
  localparam int Cpb    = 4;
`ifdef UART_TX_ARBITER_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NumReq),
    .CLKS_PER_BIT (Cpb)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line-level frame image, bit 0 = start bit; unused upper bits stay 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_ARBITER_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Observes one frame; clean=0 on unstable bits, busy low, extra ready, or non-one-hot ready.
  task automatic recv_frame(input logic [3:0] drop, output int id, output int acc,
                            output logic [10:0] bits, output bit clean);
    id    = -1;
    acc   = -1;
    bits  = '1;
    clean = 1'b0;
    for (int i = 0; i < 200 && id < 0; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        acc   = cyc;
        clean = $onehot(req_ready);
        for (int r = 0; r < 4; r++) if (req_ready[r]) id = r;
      end
    end
    if (id < 0) return;
    @(posedge clk);
    #1 req_valid = req_valid & ~drop;
    for (int j = 0; j < FrameBits; j++) begin
      for (int c = 0; c < Cpb; c++) begin
        @(negedge clk);
        if (c == 0) bits[j] = tx;
        else if (tx !== bits[j]) clean = 1'b0;
        if (busy !== 1'b1 || req_ready !== 4'b0) clean = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({tx, busy, req_ready, grant_id} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected 10000000", {tx, busy, req_ready, grant_id});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_assert++;
      if ({tx, busy, req_ready} !== 6'b10_0000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %b expected 100000", i, {tx, busy, req_ready});
      end
    end
  endtask

  task automatic test_single_byte();
    int id, acc;
    logic [10:0] bits;
    bit clean;
    exp_t e;
    do_reset();
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    sb.push_back('{0, 8'hA5});
    recv_frame(4'b0001, id, acc, bits, clean);
    e = sb.pop_front();
    n_assert++;
    if (id != e.id) begin
      n_fail++;
      $display("FAIL single_id: got %0d expected %0d", id, e.id);
    end
    n_assert++;
    if (bits !== frame_of(e.data)) begin
      n_fail++;
      $display("FAIL single_bits: got %b expected %b", bits, frame_of(e.data));
    end
    n_assert++;
    if (!clean) begin
      n_fail++;
      $display("FAIL single_clean: got 0 expected 1");
    end
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0 || tx !== 1'b1 || (cyc - acc) != FrameBits * Cpb + 1) begin
      n_fail++;
      $display("FAIL single_busy_fall: got busy=%b tx=%b at +%0d expected busy=0 tx=1 at +%0d",
               busy, tx, cyc - acc, FrameBits * Cpb + 1);
    end
  endtask

  task automatic test_round_robin();
    int id, acc, prev;
    logic [10:0] bits;
    bit clean;
    exp_t e;
    do_reset();
    req_data  = 32'h13_12_11_10;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) sb.push_back('{k % 4, 8'h10 + 8'(k % 4)});
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      recv_frame((k == 4) ? 4'b1111 : 4'b0000, id, acc, bits, clean);
      e = sb.pop_front();
      n_assert++;
      if (id != e.id || grant_id !== 2'(e.id)) begin
        n_fail++;
        $display("FAIL rr_id frame %0d: got id=%0d grant_id=%0d expected %0d",
                 k, id, grant_id, e.id);
      end
      n_assert++;
      if (bits !== frame_of(e.data) || !clean) begin
        n_fail++;
        $display("FAIL rr_bits frame %0d: got %b clean=%0b expected %b clean=1",
                 k, bits, clean, frame_of(e.data));
      end
      if (k > 0) begin
        n_assert++;
        if (acc - prev != FrameBits * Cpb + 1) begin
          n_fail++;
          $display("FAIL rr_gap frame %0d: got %0d expected %0d",
                   k, acc - prev, FrameBits * Cpb + 1);
        end
      end
      prev = acc;
    end
  endtask

  task automatic test_late_arrival();
    int id, acc, prev;
    logic [10:0] bits;
    bit clean;
    exp_t e;
    do_reset();
    req_data[7:0] = 8'h3C;
    req_valid     = 4'b0001;
    sb.push_back('{0, 8'h3C});
    sb.push_back('{2, 8'hC3});
    fork
      recv_frame(4'b0001, id, acc, bits, clean);
      begin
        repeat (22) @(negedge clk);
        req_data[23:16] = 8'hC3;
        req_valid[2]    = 1'b1;
      end
    join
    e = sb.pop_front();
    n_assert++;
    if (id != e.id || bits !== frame_of(e.data) || !clean) begin
      n_fail++;
      $display("FAIL late_first: got id=%0d bits=%b clean=%0b expected id=%0d bits=%b clean=1",
               id, bits, clean, e.id, frame_of(e.data));
    end
    prev = acc;
    recv_frame(4'b0100, id, acc, bits, clean);
    e = sb.pop_front();
    n_assert++;
    if (id != e.id || bits !== frame_of(e.data) || !clean) begin
      n_fail++;
      $display("FAIL late_second: got id=%0d bits=%b clean=%0b expected id=%0d bits=%b clean=1",
               id, bits, clean, e.id, frame_of(e.data));
    end
    n_assert++;
    if (acc - prev != FrameBits * Cpb + 1) begin
      n_fail++;
      $display("FAIL late_accept_cycle: got +%0d expected +%0d", acc - prev, FrameBits * Cpb + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int id, acc;
    logic [10:0] bits;
    bit clean;
    bit seen;
    exp_t e;
    do_reset();
    req_data[15:8] = 8'h66;
    req_valid      = 4'b0010;
    seen           = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (req_ready == 4'b0010) seen = 1'b1;
    end
    n_assert++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midrst_accept: got no ready expected ready=0010");
      return;
    end
    @(posedge clk);
    #1;
    repeat (18) @(negedge clk);
    // Cycle n+18 lies inside data bit 3, which is 0 for 0x66.
    n_assert++;
    if (tx !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_before: got tx=%b busy=%b grant_id=%0d expected tx=0 busy=1 grant_id=1",
               tx, busy, grant_id);
    end
    req_data[7:0] = 8'h77;
    req_valid     = 4'b0011;
    rst_n         = 1'b0;
    #1;
    n_assert++;
    if (tx !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got tx=%b busy=%b grant_id=%0d expected tx=1 busy=0 grant_id=0",
               tx, busy, grant_id);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back('{0, 8'h77});
    recv_frame(4'b0011, id, acc, bits, clean);
    e = sb.pop_front();
    n_assert++;
    if (id != e.id || bits !== frame_of(e.data) || !clean) begin
      n_fail++;
      $display("FAIL midrst_next: got id=%0d bits=%b clean=%0b expected id=%0d bits=%b clean=1",
               id, bits, clean, e.id, frame_of(e.data));
    end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0) seen = 1'b1;
    end
    n_assert++;
    if (seen) begin
      n_fail++;
      $display("FAIL midrst_no_reserve: got ready after drop expected none");
    end
  endtask

`ifdef UART_TX_ARBITER_PARITY_EN
  task automatic test_parity();
    int id, acc;
    logic [10:0] bits;
    bit clean;
    exp_t e;
    logic [7:0] bytes [2];
    logic       par [2];
    bytes[0] = 8'h07;
    par[0]   = 1'b1;
    bytes[1] = 8'h03;
    par[1]   = 1'b0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req_data[7:0] = bytes[k];
      req_valid     = 4'b0001;
      sb.push_back('{0, bytes[k]});
      recv_frame(4'b0001, id, acc, bits, clean);
      e = sb.pop_front();
      n_assert++;
      if (id != e.id || bits !== frame_of(e.data) || !clean) begin
        n_fail++;
        $display("FAIL parity_frame %0d: got id=%0d bits=%b clean=%0b expected id=%0d bits=%b",
                 k, id, bits, clean, e.id, frame_of(e.data));
      end
      n_assert++;
      if (bits[9] !== par[k]) begin
        n_fail++;
        $display("FAIL parity_bit %0d: got %b expected %b", k, bits[9], par[k]);
      end
      @(negedge clk);
      n_assert++;
      if (busy !== 1'b0 || (cyc - acc) != 11 * Cpb + 1) begin
        n_fail++;
        $display("FAIL parity_len %0d: got busy=%b at +%0d expected busy=0 at +%0d",
                 k, busy, cyc - acc, 11 * Cpb + 1);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_late_arrival();
    test_reset_mid_frame();
`ifdef UART_TX_ARBITER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
